acid_dose_ctrl: RTL and testbench



---
 rtl/acid_dose_pkg.sv | 23 ++
 rtl/acid_dose_ctrl_if.sv | 21 ++
 rtl/dose_tick_gen.sv | 26 ++
 rtl/acid_dose_ctrl.sv | 144 ++++++++++++++
 tb/tb_acid_dose_ctrl.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/acid_dose_pkg.sv
// Shared types and helpers for the acid dosing pump controller.
//   dose_state_e : FSM state, 3-bit encoding, also exported on state_o.
//   duty_max_f   : full-scale duty for a given PWM counter width.
//   cnt_w_f      : bits needed to hold a counter that counts 0..max_val.
package acid_dose_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RAMP    = 3'd1,
        ST_RUN     = 3'd2,
        ST_HOLDOFF = 3'd3,
        ST_FAULT   = 3'd4
    } dose_state_e;

    function automatic int duty_max_f(input int bits);
        return (1 << bits) - 1;
    endfunction

    function automatic int cnt_w_f(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/acid_dose_ctrl_if.sv
// Request/status bundle between the acid PIO and the dosing controller.
//   dose_req, fault_clr : from firmware (master) to controller (slave)
//   pump_on, pump_pwm, fault, state_o : controller status / drive
interface acid_dose_ctrl_if;
    logic       dose_req;
    logic       fault_clr;
    logic       pump_on;
    logic       pump_pwm;
    logic       fault;
    logic [2:0] state_o;

    modport master (
        output dose_req, fault_clr,
        input  pump_on, pump_pwm, fault, state_o
    );

    modport slave (
        input  dose_req, fault_clr,
        output pump_on, pump_pwm, fault, state_o
    );
endinterface

// File: rtl/dose_tick_gen.sv
// Free-running prescaler producing a one-clk tick every TICK_DIV clocks.
//   clk, reset_n : clock, async active-low reset
//   tick         : high for the cycle in which the count equals TICK_DIV-1
module dose_tick_gen #(
    parameter int TICK_DIV = 50000
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);
    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt <= '0;
        else if (cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    assign tick = (cnt == LAST);
endmodule

// File: rtl/acid_dose_ctrl.sv
// Acid dosing pump controller. Turns the acid PIO request into a pump drive
// with minimum on/off times, a soft-start PWM ramp and a latched max-on fault.
//   clk, reset_n : clock, async active-low reset
//   bus.dose_req : dose request (asynchronous, synchronized here)
//   bus.fault_clr: one-cycle pulse, clears a latched fault once req is low
//   bus.pump_on  : pump enable
//   bus.pump_pwm : PWM gate drive (one clk behind pump_on / duty)
//   bus.fault    : latched max-on timeout
//   bus.state_o  : FSM state for readback
module acid_dose_ctrl
    import acid_dose_pkg::*;
#(
    parameter int TICK_DIV      = 50000,
    parameter int MIN_ON_TICKS  = 2000,
    parameter int MIN_OFF_TICKS = 5000,
    parameter int MAX_ON_TICKS  = 60000,
    parameter int PWM_BITS      = 8,
    parameter int RAMP_STEP     = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    acid_dose_ctrl_if.slave  bus
);
    localparam int DUTY_MAX = duty_max_f(PWM_BITS);
    localparam int ON_W     = cnt_w_f(MAX_ON_TICKS);
    localparam int OFF_W    = cnt_w_f(MIN_OFF_TICKS);

    localparam logic [PWM_BITS-1:0] DUTY_FULL = PWM_BITS'(DUTY_MAX);
    localparam logic [PWM_BITS-1:0] STEP      = PWM_BITS'(RAMP_STEP);
    localparam logic [ON_W-1:0]     MAX_ON    = ON_W'(MAX_ON_TICKS);
    localparam logic [ON_W-1:0]     MIN_ON    = ON_W'(MIN_ON_TICKS);
    localparam logic [OFF_W-1:0]    MIN_OFF   = OFF_W'(MIN_OFF_TICKS);

    dose_state_e         state;
    logic                req_m, req_s;
    logic                tick;
    logic [PWM_BITS-1:0] duty, duty_nxt, pwm_cnt;
    logic [ON_W-1:0]     on_timer, on_nxt;
    logic [OFF_W-1:0]    off_timer, off_nxt;
    logic                pump_on_q, pump_pwm_q, fault_q;

    dose_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick)
    );

    // Saturating next values; the FSM decides on these so a threshold
    // crossing acts on the same tick edge that reaches it.
    always_comb begin
        on_nxt  = (on_timer >= MAX_ON) ? MAX_ON : on_timer + 1'b1;
        off_nxt = (off_timer >= MIN_OFF) ? MIN_OFF : off_timer + 1'b1;
        if (int'(duty) + RAMP_STEP >= DUTY_MAX)
            duty_nxt = DUTY_FULL;
        else
            duty_nxt = duty + STEP;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_m      <= 1'b0;
            req_s      <= 1'b0;
            pwm_cnt    <= '0;
            pump_pwm_q <= 1'b0;
        end else begin
            req_m      <= bus.dose_req;
            req_s      <= req_m;
            pwm_cnt    <= pwm_cnt + 1'b1;
            pump_pwm_q <= pump_on_q & ((duty == DUTY_FULL) | (pwm_cnt < duty));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            pump_on_q <= 1'b0;
            fault_q   <= 1'b0;
            duty      <= '0;
            on_timer  <= '0;
            off_timer <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    pump_on_q <= 1'b0;
                    duty      <= '0;
                    if (req_s) begin
                        state     <= ST_RAMP;
                        pump_on_q <= 1'b1;
                        on_timer  <= '0;
                    end
                end
                ST_RAMP, ST_RUN: begin
                    if (tick)
                        on_timer <= on_nxt;
                    // Timeout wins over a release landing on the same edge.
                    if (tick && on_nxt == MAX_ON) begin
                        state     <= ST_FAULT;
                        fault_q   <= 1'b1;
                        pump_on_q <= 1'b0;
                        duty      <= '0;
                    end else if (!req_s && on_timer >= MIN_ON) begin
                        state     <= ST_HOLDOFF;
                        pump_on_q <= 1'b0;
                        duty      <= '0;
                        off_timer <= '0;
                    end else if (state == ST_RAMP && tick) begin
                        duty <= duty_nxt;
                        if (duty_nxt == DUTY_FULL)
                            state <= ST_RUN;
                    end
                end
                ST_HOLDOFF: begin
                    pump_on_q <= 1'b0;
                    duty      <= '0;
                    if (tick) begin
                        off_timer <= off_nxt;
                        if (off_nxt >= MIN_OFF)
                            state <= ST_IDLE;
                    end
                end
                ST_FAULT: begin
                    pump_on_q <= 1'b0;
                    duty      <= '0;
                    // Firmware must drop the request before the clear is honoured.
                    if (bus.fault_clr && !req_s) begin
                        state     <= ST_HOLDOFF;
                        fault_q   <= 1'b0;
                        off_timer <= '0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    pump_on_q <= 1'b0;
                    duty      <= '0;
                end
            endcase
        end
    end

    assign bus.pump_on  = pump_on_q;
    assign bus.pump_pwm = pump_pwm_q;
    assign bus.fault    = fault_q;
    assign bus.state_o  = state;
endmodule

// File: tb/tb_acid_dose_ctrl.sv
// Directed bench for acid_dose_ctrl. u1 runs the small test-plan timing;
// u2 uses a long tick so a single duty level lasts a full PWM period.
module tb_acid_dose_ctrl;
    logic clk, reset_n;
    int   tests = 0, fails = 0;
    int   E = 0;  // posedges since last reset release

    acid_dose_ctrl_if bus1();
    acid_dose_ctrl_if bus2();

    acid_dose_ctrl #(
        .TICK_DIV(4), .MIN_ON_TICKS(3), .MIN_OFF_TICKS(2),
        .MAX_ON_TICKS(20), .PWM_BITS(4), .RAMP_STEP(4)
    ) u1 (.clk(clk), .reset_n(reset_n), .bus(bus1));

    acid_dose_ctrl #(
        .TICK_DIV(64), .MIN_ON_TICKS(3), .MIN_OFF_TICKS(2),
        .MAX_ON_TICKS(1000), .PWM_BITS(4), .RAMP_STEP(4)
    ) u2 (.clk(clk), .reset_n(reset_n), .bus(bus2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit       rst;  // pulse reset first, restart edge count
        int       e;    // edge count at which to check, then drive
        bit       req;
        bit       clr;
        bit       chk;
        bit [2:0] st;
        bit       on;
        bit       flt;
    } vec_t;

    vec_t vq[$];

    task automatic add(input bit rst, input int e, input bit req, input bit clr,
                       input bit chk, input bit [2:0] st, input bit on, input bit flt);
        vec_t v;
        v = '{rst, e, req, clr, chk, st, on, flt};
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        E++;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        bus1.dose_req = 1'b0; bus1.fault_clr = 1'b0;
        bus2.dose_req = 1'b0; bus2.fault_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        E = 0;
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            if (vq[i].rst) do_reset();
            while (E < vq[i].e) step();
            if (vq[i].chk) begin
                chk($sformatf("v%0d@%0d state", i, E), 32'(bus1.state_o), 32'(vq[i].st));
                chk($sformatf("v%0d@%0d pump_on", i, E), 32'(bus1.pump_on), 32'(vq[i].on));
                chk($sformatf("v%0d@%0d fault", i, E), 32'(bus1.fault), 32'(vq[i].flt));
            end
            bus1.dose_req  = vq[i].req;
            bus1.fault_clr = vq[i].clr;
        end
    endtask

    int a_end, b_end, c_end, d_end;
    int hi_cnt;

    initial begin
        reset_n = 1'b0;
        bus1.dose_req = 1'b0; bus1.fault_clr = 1'b0;
        bus2.dose_req = 1'b0; bus2.fault_clr = 1'b0;

        // A: soft-start ramp into RUN (ticks land on edges 4,8,12,16)
        add(1,  0, 1, 0, 1, 3'd0, 0, 0);
        add(0,  2, 1, 0, 1, 3'd0, 0, 0);
        add(0,  3, 1, 0, 1, 3'd1, 1, 0);
        add(0, 15, 1, 0, 1, 3'd1, 1, 0);
        add(0, 16, 1, 0, 1, 3'd2, 1, 0);
        a_end = vq.size();
        // B: 2-clk request, release deferred until on_timer=3, holdoff 2 ticks
        add(1,  0, 1, 0, 1, 3'd0, 0, 0);
        add(0,  2, 0, 0, 1, 3'd0, 0, 0);
        add(0,  3, 0, 0, 1, 3'd1, 1, 0);
        add(0, 12, 0, 0, 1, 3'd1, 1, 0);
        add(0, 13, 0, 0, 1, 3'd3, 0, 0);
        add(0, 19, 0, 0, 1, 3'd3, 0, 0);
        add(0, 20, 0, 0, 1, 3'd0, 0, 0);
        add(0, 30, 0, 0, 1, 3'd0, 0, 0);
        b_end = vq.size();
        // C: request toggled during holdoff is ignored, restart right after IDLE
        add(1,  0, 1, 0, 0, 3'd0, 0, 0);
        add(0,  2, 0, 0, 0, 3'd0, 0, 0);
        add(0, 13, 1, 0, 1, 3'd3, 0, 0);
        add(0, 14, 0, 0, 1, 3'd3, 0, 0);
        add(0, 15, 1, 0, 1, 3'd3, 0, 0);
        add(0, 19, 1, 0, 1, 3'd3, 0, 0);
        add(0, 20, 1, 0, 1, 3'd0, 0, 0);
        add(0, 21, 1, 0, 1, 3'd1, 1, 0);
        c_end = vq.size();
        // D: max-on timeout on tick 20 (edge 80), clear gated by request
        add(1,   0, 1, 0, 0, 3'd0, 0, 0);
        add(0,  16, 1, 0, 1, 3'd2, 1, 0);
        add(0,  79, 1, 0, 1, 3'd2, 1, 0);
        add(0,  80, 1, 0, 1, 3'd4, 0, 1);
        add(0, 100, 1, 1, 1, 3'd4, 0, 1);
        add(0, 101, 0, 0, 1, 3'd4, 0, 1);
        add(0, 105, 0, 1, 1, 3'd4, 0, 1);
        add(0, 106, 0, 0, 1, 3'd3, 0, 0);
        add(0, 111, 0, 0, 1, 3'd3, 0, 0);
        add(0, 112, 0, 0, 1, 3'd0, 0, 0);
        d_end = vq.size();

        run_vecs(0, a_end);
        // Full duty in RUN: PWM steady high
        hi_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            hi_cnt += int'(bus1.pump_pwm);
        end
        chk("run pwm high count", 32'(hi_cnt), 32'd8);
        // Async reset mid-RUN, between edges
        #2 reset_n = 1'b0;
        #1;
        chk("async rst pump_on", 32'(bus1.pump_on), 32'd0);
        chk("async rst pump_pwm", 32'(bus1.pump_pwm), 32'd0);
        chk("async rst fault", 32'(bus1.fault), 32'd0);
        chk("async rst state", 32'(bus1.state_o), 32'd0);

        run_vecs(a_end, b_end);
        run_vecs(b_end, c_end);
        run_vecs(c_end, d_end);
        step();
        chk("fault pwm low", 32'(bus1.pump_pwm), 32'd0);

        // PWM duty on u2: duty 4 during edges 64..127, duty 8 during 128..191
        do_reset();
        bus2.dose_req = 1'b1;
        while (E < 65) step();
        hi_cnt = 0;
        for (int k = 0; k < 16; k++) begin
            step();
            hi_cnt += int'(bus2.pump_pwm);
        end
        chk("pwm duty4 high count", 32'(hi_cnt), 32'd4);
        while (E < 129) step();
        hi_cnt = 0;
        for (int k = 0; k < 16; k++) begin
            step();
            hi_cnt += int'(bus2.pump_pwm);
        end
        chk("pwm duty8 high count", 32'(hi_cnt), 32'd8);
        chk("pwm u2 state", 32'(bus2.state_o), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
